spi_flash_slave: RTL and testbench

- Synthesizable SPI flash responder: the device end of the serial flash link driven by the flash controller.
- Decodes the same opcode set: READ 0x03, WREN 0x06, PP 0x02, SE 0xD8, BE 0xC7, RDSR 0x05.
- Backed by an internal byte array; used as an on-chip flash stand-in for system simulation and FPGA bring-up.
- All SPI pins are oversampled in the single system clock domain.

---
 rtl/spi_flash_slave.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_flash_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_slave.sv
// rtl/spi_flash_slave.sv - SPI flash responder over an on-chip byte array, oversampled in clk.
// Optional JEDEC RDID (0x9F) response is built when SPI_FLASH_SLAVE_RDID_EN is defined.
module spi_flash_slave #(
    parameter int ADDR_W  = 8,
    parameter int SECT_W  = 4,
    parameter int PP_BUSY = 64
`ifdef SPI_FLASH_SLAVE_RDID_EN
    ,
    parameter logic [23:0] JEDEC_ID = 24'hC22017
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic CLK,
    input  logic CS,
    input  logic D,
    output logic Q,
    output logic wip
);
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_RDSR = 8'h05;
`ifdef SPI_FLASH_SLAVE_RDID_EN
    localparam logic [7:0] OP_RDID = 8'h9F;
`endif
    localparam logic [ADDR_W-1:0] A_ONE    = 1;
    localparam logic [SECT_W-1:0] SECT_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RD_DATA, ST_PP_DATA, ST_STATUS, ST_IGNORE
`ifdef SPI_FLASH_SLAVE_RDID_EN
        , ST_RDID
`endif
    } state_t;

    logic [7:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [2:0]        sclk_q, sclk_d, cs_q, cs_d;
    logic [1:0]        din_q, din_d;
    logic [5:0]        nbits_q, nbits_d;
    logic [2:0]        idx_q, idx_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        op_q, op_d, tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d, er_addr_q, er_addr_d, er_end_q, er_end_d;
    logic              q_q, q_d, wip_q, wip_d, erase_q, erase_d, pp_any_q, pp_any_d;
    logic [1:0]        status_q, status_d;
    logic [15:0]       busy_q, busy_d;
`ifdef SPI_FLASH_SLAVE_RDID_EN
    logic [1:0]        id_cnt_q, id_cnt_d;
    logic [7:0]        id_byte;
    assign id_byte = (id_cnt_q == 2'd0) ? JEDEC_ID[23:16] :
                     (id_cnt_q == 2'd1) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
`endif

    logic              sck_rise, sck_fall, cs_rise, cs_fall, din, mem_we;
    logic [7:0]        rx_byte, mem_rd, mem_wd;
    logic [ADDR_W-1:0] mem_wa;

    assign sck_rise = sclk_q[1] & ~sclk_q[2];
    assign sck_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign din      = din_q[1];
    assign rx_byte  = {rx_q, din};
    assign mem_rd   = mem[addr_q];
    assign Q        = q_q;
    assign wip      = wip_q;

    always_comb begin
        sclk_d    = {sclk_q[1:0], CLK};
        cs_d      = {cs_q[1:0], CS};
        din_d     = {din_q[0], D};
        state_d   = state_q;
        nbits_d   = nbits_q;
        idx_d     = idx_q;
        rx_d      = rx_q;
        op_d      = op_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        q_d       = q_q;
        status_d  = status_q;
        wip_d     = status_q[0];
        busy_d    = busy_q;
        erase_d   = erase_q;
        er_addr_d = er_addr_q;
        er_end_d  = er_end_q;
        pp_any_d  = pp_any_q;
`ifdef SPI_FLASH_SLAVE_RDID_EN
        id_cnt_d  = id_cnt_q;
`endif
        mem_we    = 1'b0;
        mem_wa    = addr_q;
        mem_wd    = 8'hFF;

        // Background program timer and erase engine; both only run while WIP=1,
        // which keeps them from ever colliding with a PP_DATA write.
        if (busy_q != 16'd0) begin
            busy_d = busy_q - 16'd1;
            if (busy_q == 16'd1) status_d = 2'b00;
        end
        if (erase_q) begin
            mem_we    = 1'b1;
            mem_wa    = er_addr_q;
            er_addr_d = er_addr_q + A_ONE;
            if (er_addr_q == er_end_q) begin
                erase_d  = 1'b0;
                status_d = 2'b00;
            end
        end

        if (cs_rise) begin
            state_d = ST_IDLE;
            q_d     = 1'b0;
            tx_d    = 8'h00;
            op_d    = 8'h00;
            if (op_q == OP_WREN && nbits_q == 6'd8) begin
                status_d[1] = 1'b1;
            end else if (status_q[1]) begin
                if (op_q == OP_PP && pp_any_q) begin
                    status_d[0] = 1'b1;
                    busy_d      = 16'(PP_BUSY);
                end else if (op_q == OP_SE && nbits_q == 6'd32) begin
                    status_d[0] = 1'b1;
                    erase_d     = 1'b1;
                    er_addr_d   = {addr_q[ADDR_W-1:SECT_W], {SECT_W{1'b0}}};
                    er_end_d    = {addr_q[ADDR_W-1:SECT_W], {SECT_W{1'b1}}};
                end else if (op_q == OP_BE && nbits_q == 6'd8) begin
                    status_d[0] = 1'b1;
                    erase_d     = 1'b1;
                    er_addr_d   = '0;
                    er_end_d    = '1;
                end
            end
        end else if (cs_fall) begin
            state_d  = ST_CMD;
            nbits_d  = 6'd0;
            idx_d    = 3'd0;
            op_d     = 8'h00;
            pp_any_d = 1'b0;
            q_d      = 1'b0;
        end else if (state_q != ST_IDLE && sck_rise) begin
            rx_d  = rx_byte[6:0];
            idx_d = idx_q + 3'd1;
            if (nbits_q != 6'd63) nbits_d = nbits_q + 6'd1;
            case (state_q)
                ST_CMD: if (idx_q == 3'd7) begin
                    if (status_q[0] && rx_byte != OP_RDSR) begin
                        state_d = ST_IGNORE;
                    end else begin
                        op_d = rx_byte;
                        case (rx_byte)
                            OP_READ, OP_PP, OP_SE: state_d = ST_ADDR;
                            OP_RDSR:               state_d = ST_STATUS;
`ifdef SPI_FLASH_SLAVE_RDID_EN
                            OP_RDID: begin
                                state_d  = ST_RDID;
                                id_cnt_d = 2'd0;
                            end
`endif
                            default:               state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    addr_d = {addr_q[ADDR_W-2:0], din};
                    if (nbits_q == 6'd31) begin
                        if (op_q == OP_READ)                  state_d = ST_RD_DATA;
                        else if (op_q == OP_PP && status_q[1]) state_d = ST_PP_DATA;
                        else                                   state_d = ST_IGNORE;
                    end
                end
                ST_PP_DATA: if (idx_q == 3'd7) begin
                    mem_we   = 1'b1;
                    mem_wd   = mem_rd & rx_byte;
                    addr_d   = {addr_q[ADDR_W-1:SECT_W], addr_q[SECT_W-1:0] + SECT_ONE};
                    pp_any_d = 1'b1;
                end
                default: ;
            endcase
        end else if (state_q != ST_IDLE && sck_fall) begin
            // Byte boundaries fall on idx 0; load there, otherwise shift.
            q_d  = tx_q[7];
            tx_d = {tx_q[6:0], 1'b0};
            case (state_q)
                ST_RD_DATA: if (idx_q == 3'd0) begin
                    q_d    = mem_rd[7];
                    tx_d   = {mem_rd[6:0], 1'b0};
                    addr_d = addr_q + A_ONE;
                end
                ST_STATUS: if (idx_q == 3'd0) begin
                    q_d  = 1'b0;
                    tx_d = {5'b0, status_q, 1'b0};
                end
`ifdef SPI_FLASH_SLAVE_RDID_EN
                ST_RDID: if (idx_q == 3'd0) begin
                    if (id_cnt_q != 2'd3) begin
                        q_d      = id_byte[7];
                        tx_d     = {id_byte[6:0], 1'b0};
                        id_cnt_d = id_cnt_q + 2'd1;
                    end else begin
                        q_d  = 1'b0;
                        tx_d = 8'h00;
                    end
                end
`endif
                default: begin
                    q_d  = 1'b0;
                    tx_d = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 3'b000;
            cs_q      <= 3'b111;
            din_q     <= 2'b00;
            nbits_q   <= 6'd0;
            idx_q     <= 3'd0;
            rx_q      <= 7'd0;
            op_q      <= 8'h00;
            addr_q    <= '0;
            tx_q      <= 8'h00;
            q_q       <= 1'b0;
            status_q  <= 2'b00;
            wip_q     <= 1'b0;
            busy_q    <= 16'd0;
            erase_q   <= 1'b0;
            er_addr_q <= '0;
            er_end_q  <= '0;
            pp_any_q  <= 1'b0;
`ifdef SPI_FLASH_SLAVE_RDID_EN
            id_cnt_q  <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            din_q     <= din_d;
            nbits_q   <= nbits_d;
            idx_q     <= idx_d;
            rx_q      <= rx_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            q_q       <= q_d;
            status_q  <= status_d;
            wip_q     <= wip_d;
            busy_q    <= busy_d;
            erase_q   <= erase_d;
            er_addr_q <= er_addr_d;
            er_end_q  <= er_end_d;
            pp_any_q  <= pp_any_d;
`ifdef SPI_FLASH_SLAVE_RDID_EN
            id_cnt_q  <= id_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end
endmodule

// File: tb/tb_spi_flash_slave.sv
// tb/tb_spi_flash_slave.sv - random SPI flash traffic checked against a byte-array flash model.
`timescale 1ns/1ps
module tb_spi_flash_slave;
    localparam int H   = 4;
    localparam int PPB = 300;

    logic clk = 1'b0, reset_n = 1'b0, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, wip;

    spi_flash_slave #(.ADDR_W(8), .SECT_W(4), .PP_BUSY(PPB)) dut (
        .clk(clk), .reset_n(reset_n), .CLK(sck), .CS(cs_n), .D(mosi), .Q(miso), .wip(wip)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    val;
    } item_t;

    item_t      exp_q[$];
    item_t      got_q[$];
    item_t      e_it, g_it;
    int         errors = 0;
    int         checks = 0;
    int         wip_run = 0;
    int         wip_len = 0;
    logic [7:0] mem_m [256];
    bit         wel_m = 1'b0;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_it = exp_q.pop_front();
            g_it = got_q.pop_front();
            checks++;
            if (g_it.val != e_it.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h required 0x%0h", e_it.name, g_it.val, e_it.val);
            end
        end
        if (wip === 1'b1) wip_run++;
        else if (wip_run > 0) begin
            wip_len = wip_run;
            wip_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string nm, input int v);
        item_t it;
        it.name = nm;
        it.val  = v;
        exp_q.push_back(it);
    endtask

    task automatic observe(input int v);
        item_t it;
        it.name = "";
        it.val  = v;
        got_q.push_back(it);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            tick(H);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            tick(H);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] r;
        spi_bits(tx, 8, r);
    endtask

    task automatic cs_on();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_off();
        tick(2);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic send_addr(input logic [23:0] a);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (wip !== 1'b0 && n < 5000) begin
            tick(1);
            n++;
        end
        expect_v(nm, 0);
        observe((n >= 5000) ? 1 : 0);
        tick(3);
    endtask

    task automatic wren();
        cs_on();
        spi_byte(8'h06);
        cs_off();
        wel_m = 1'b1;
    endtask

    task automatic rdsr(input string nm, input logic [7:0] ev);
        logic [7:0] r;
        expect_v(nm, ev);
        cs_on();
        spi_byte(8'h05);
        spi_bits(8'h00, 8, r);
        cs_off();
        observe(r);
    endtask

    task automatic pp(input logic [23:0] a, input logic [7:0] data[$]);
        int ad;
        if (wel_m && data.size() > 0) begin
            ad = a[7:0];
            foreach (data[k]) begin
                mem_m[ad] = mem_m[ad] & data[k];
                ad = (ad & 8'hF0) | ((ad + 1) & 8'h0F);
            end
            wel_m = 1'b0;
        end
        cs_on();
        spi_byte(8'h02);
        send_addr(a);
        foreach (data[k]) spi_byte(data[k]);
        cs_off();
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input int lo, input int hi);
        logic [7:0] r;
        int ad;
        for (int k = 0; k < n; k++) begin
            ad = (int'(a[7:0]) + k) % 256;
            if (!(ad >= lo && ad < hi)) expect_v($sformatf("read@%02h", ad), mem_m[ad]);
        end
        cs_on();
        spi_byte(8'h03);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            spi_bits(8'h00, 8, r);
            ad = (int'(a[7:0]) + k) % 256;
            if (!(ad >= lo && ad < hi)) observe(r);
        end
        cs_off();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dq[$];
        logic [7:0] r;
        int a, n;

        tick(5);
        expect_v("reset_wip", 0);
        observe(wip);
        if (wip !== 1'b0) begin
            errors++;
            $display("FAIL reset_wip_direct: got %b required 0", wip);
        end
        reset_n = 1'b1;
        tick(5);
        rdsr("rdsr_after_reset", 8'h00);

        wren();
        cs_on(); spi_byte(8'hC7); cs_off();
        rdsr("rdsr_during_be", 8'h03);
        wait_idle("be_done");
        for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
        wel_m = 1'b0;
        rdsr("rdsr_after_be", 8'h00);

        dq = {8'h5A};
        pp(24'h000010, dq);
        rdsr("pp_no_wren_wip", 8'h00);
        do_read(24'h000010, 1, 0, 0);

        wren();
        dq = {8'hF0};
        pp(24'h000010, dq);
        wait_idle("pp1_done");
        wren();
        dq = {8'h5A, 8'hF0};
        pp(24'h000010, dq);
        rdsr("rdsr_pp_busy", 8'h03);
        wait_idle("pp2_done");
        expect_v("pp_busy_len", PPB);
        observe(wip_len);
        rdsr("rdsr_pp_done", 8'h00);
        do_read(24'h000010, 2, 0, 0);

        for (int it = 0; it < 5; it++) begin
            a = $urandom_range(0, 255);
            n = $urandom_range(1, 20);
            dq = {};
            for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
            wren();
            pp({8'($urandom), 8'($urandom), 8'(a)}, dq);
            wait_idle("pp_rand_done");
            do_read({16'h0000, 8'(a & 8'hF0)}, 16, 0, 0);
            do_read(24'($urandom), $urandom_range(1, 6), 0, 0);
        end

        wren();
        dq = {8'h3C};
        pp(24'h000020, dq);
        wait_idle("pp20_done");
        wren();
        cs_on(); spi_byte(8'hD8); send_addr(24'h000013); cs_off();
        wait_idle("se_done");
        for (int i = 16'h10; i < 16'h20; i++) mem_m[i] = 8'hFF;
        wel_m = 1'b0;
        expect_v("se_wip_len", 16);
        observe(wip_len);
        do_read(24'h000010, 16, 0, 0);
        do_read(24'h000020, 1, 0, 0);
        do_read(24'h0000FF, 2, 0, 0);

        cs_on(); spi_byte(8'h06); spi_bits(8'h80, 1, r); cs_off();
        rdsr("wren_9bits", 8'h00);
        wren();
        rdsr("wel_set", 8'h02);
        cs_on(); spi_byte(8'hD8); spi_byte(8'h00); spi_byte(8'h00); spi_bits(8'h10, 7, r); cs_off();
        rdsr("se_31bits", 8'h02);
        do_read(24'h000010, 2, 0, 0);

        for (int k = 0; k < 3; k++) begin
`ifdef SPI_FLASH_SLAVE_RDID_EN
            expect_v("rdid", (k == 0) ? 8'hC2 : (k == 1) ? 8'h20 : 8'h17);
`else
            expect_v("rdid_unknown", 8'h00);
`endif
        end
        cs_on();
        spi_byte(8'h9F);
        for (int k = 0; k < 3; k++) begin
            spi_bits(8'h00, 8, r);
            observe(r);
        end
        cs_off();

        cs_on(); spi_byte(8'hC7); cs_off();
        tick(60);
        reset_n = 1'b0;
        tick(3);
        expect_v("wip_after_abort", 0);
        observe(wip);
        reset_n = 1'b1;
        tick(3);
        wel_m = 1'b0;
        for (int i = 0; i < 40; i++) mem_m[i] = 8'hFF;
        rdsr("rdsr_after_abort", 8'h00);
        do_read(24'h000000, 256, 40, 90);

        tick(10);
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count: only %0d checks ran", checks);
        end
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL unmatched: %0d expected, %0d observed left", exp_q.size(), got_q.size());
        end
        if (errors == 0) $display("PASS");
        else $display("FAIL");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
